// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam int          PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the PC, instruction-memory and decode-side signals around the fetch unit.
interface instr_fetch_unit_if #(
    parameter int N_BITS = 32
) ();
    logic [N_BITS-1:0] pc_value_i;
    logic              pc_write_o;
    logic [N_BITS-1:0] new_pc_o;
    logic              redirect_i;
    logic [N_BITS-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [N_BITS-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [N_BITS-1:0] imem_rdata_i;
    logic              instr_valid_o;
    logic [N_BITS-1:0] instr_o;
    logic [N_BITS-1:0] instr_pc_o;
    logic              instr_ready_i;
    logic              misaligned_o;

    // The fetch unit itself
    modport master (
        input  pc_value_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, instr_ready_i,
        output pc_write_o, new_pc_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o,
        output instr_pc_o, misaligned_o
    );

    // PC, memory and decode stage surrounding it
    modport slave (
        output pc_value_i, redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, instr_ready_i,
        input  pc_write_o, new_pc_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o,
        input  instr_pc_o, misaligned_o
    );
endinterface

// File: rtl/instr_skid_buf.sv
// Two-entry {pc, instr} FIFO with registered head, flush, and simultaneous push/pop.
module instr_skid_buf #(
    parameter int             W        = 32,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_pc,
    input  logic [W-1:0] push_instr,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_pc,
    output logic [W-1:0] head_instr,
    output logic [1:0]   count
);
    logic [1:0][W-1:0] pc_reg, pc_next;
    logic [1:0][W-1:0] instr_reg, instr_next;
    logic [1:0]        count_reg, count_next;
    logic [1:0]        wr_idx;

    // A push lands in the slot left free after this cycle's pop has shifted the queue.
    assign wr_idx = count_reg - {1'b0, pop};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            if (gi < 1) begin : g_shift
                assign pc_next[gi]    = (flush) ? pc_reg[gi] :
                                        (push && wr_idx == 2'(gi)) ? push_pc :
                                        (pop) ? pc_reg[gi+1] : pc_reg[gi];
                assign instr_next[gi] = (flush) ? instr_reg[gi] :
                                        (push && wr_idx == 2'(gi)) ? push_instr :
                                        (pop) ? instr_reg[gi+1] : instr_reg[gi];
            end else begin : g_tail
                assign pc_next[gi]    = (!flush && push && wr_idx == 2'(gi)) ? push_pc : pc_reg[gi];
                assign instr_next[gi] = (!flush && push && wr_idx == 2'(gi)) ? push_instr : instr_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            count_next = count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                pc_reg[i]    <= RESET_PC;
                instr_reg[i] <= '0;
            end
            count_reg <= 2'd0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            count_reg <= count_next;
        end
    end

    assign head_valid = (count_reg != 2'd0);
    assign head_pc    = pc_reg[0];
    assign head_instr = instr_reg[0];
    assign count      = count_reg;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one outstanding imem request at a time, updates the PC on ack or
// redirect, and queues fetched words for decode.
module instr_fetch_unit #(
    parameter int                N_BITS   = 32,
    parameter logic [N_BITS-1:0] RESET_PC = N_BITS'(fetch_pkg::RESET_PC)
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    import fetch_pkg::*;

    fetch_state_e      state_reg;
    logic              req_reg;
    logic [N_BITS-1:0] addr_reg;
    logic              misaligned_reg;

    logic              buf_valid;
    logic [1:0]        buf_count;
    logic [1:0]        count_after_pop;
    logic              pop;
    logic              ack_take;
    logic              can_issue;
    logic              pc_aligned;
    logic              issue;
    logic              flag_misalign;

    assign pop             = buf_valid & bus.instr_ready_i;
    assign ack_take        = (state_reg == REQ) & bus.imem_ack_i & ~bus.redirect_i;
    assign count_after_pop = buf_count - {1'b0, pop};
    assign pc_aligned      = (bus.pc_value_i[1:0] == 2'b00);
    assign can_issue       = (state_reg == IDLE) & ~bus.redirect_i & ~misaligned_reg;
    assign issue           = can_issue & pc_aligned & (count_after_pop < 2'd2);
    assign flag_misalign   = can_issue & ~pc_aligned;

    // Redirect outranks the sequential update when both land in the same cycle.
    always_comb begin
        bus.pc_write_o = 1'b1;
        bus.new_pc_o   = bus.pc_value_i;
        if (bus.redirect_i) begin
            bus.pc_write_o = 1'b0;
            bus.new_pc_o   = bus.redirect_pc_i;
        end else if (ack_take) begin
            bus.pc_write_o = 1'b0;
            bus.new_pc_o   = addr_reg + N_BITS'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            req_reg        <= 1'b0;
            addr_reg       <= '0;
            misaligned_reg <= 1'b0;
        end else begin
            if (flag_misalign) begin
                misaligned_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        req_reg   <= 1'b1;
                        addr_reg  <= bus.pc_value_i;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (bus.imem_ack_i) begin
                        req_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (bus.redirect_i) begin
                        state_reg <= DROP;
                    end
                end
                DROP: begin
                    // Request stays up until the memory answers; its data is discarded.
                    if (bus.imem_ack_i) begin
                        req_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    instr_skid_buf #(
        .W        (N_BITS),
        .RESET_PC (RESET_PC)
    ) u_skid_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.redirect_i),
        .push       (ack_take),
        .push_pc    (addr_reg),
        .push_instr (bus.imem_rdata_i),
        .pop        (pop),
        .head_valid (buf_valid),
        .head_pc    (bus.instr_pc_o),
        .head_instr (bus.instr_o),
        .count      (buf_count)
    );

    assign bus.imem_req_o    = req_reg;
    assign bus.imem_addr_o   = addr_reg;
    assign bus.instr_valid_o = buf_valid;
    assign bus.misaligned_o  = misaligned_reg;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: emulates the PC register and a variable-latency memory.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;

    instr_fetch_unit_if #(.N_BITS(32)) bus ();

    instr_fetch_unit #(
        .N_BITS   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb_pc[$];
    logic [31:0] sb_instr[$];
    logic [31:0] issue_log[$];
    logic [31:0] ack_np_log[$];
    int          acks_taken = 0;
    int          acks_dropped = 0;
    int          mem_lat = 1;
    bit          rand_lat = 0;
    int          wait_cnt = 0;
    int          cur_lat = 0;
    bit          prev_req = 0;
    bit          squashed = 0;
    logic [31:0] held_addr = '0;
    bit          arm_redirect = 0;
    logic [31:0] arm_target = '0;
    int          fired_cnt = 0;
    logic [31:0] fired_np = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: memory model, per-cycle checks, scoreboard, then PC register update.
    task automatic cyc();
        logic        pw;
        logic [31:0] np;
        logic        exp_pw;
        logic [31:0] exp_np;
        bit          ack;
        bit          acc;
        bit          fired_now;
        @(negedge clk);
        ack = 0;
        fired_now = 0;
        if (reset && bus.imem_req_o) begin
            if (!prev_req) begin
                wait_cnt = 0;
                cur_lat = rand_lat ? int'($urandom_range(0, 2)) : mem_lat;
                held_addr = bus.imem_addr_o;
                vectors++;
                if (bus.imem_addr_o !== bus.pc_value_i) begin
                    miscompares++;
                    $display("FAIL issue_addr: got %h want %h", bus.imem_addr_o, bus.pc_value_i);
                end
                issue_log.push_back(bus.imem_addr_o);
            end else begin
                vectors++;
                if (bus.imem_addr_o !== held_addr) begin
                    miscompares++;
                    $display("FAIL addr_hold: got %h want %h", bus.imem_addr_o, held_addr);
                end
            end
            ack = (wait_cnt == cur_lat);
            wait_cnt++;
        end
        prev_req = reset && bus.imem_req_o;
        if (ack && arm_redirect) begin
            bus.redirect_i    = 1'b1;
            bus.redirect_pc_i = arm_target;
            bus.instr_ready_i = 1'b1;
            arm_redirect = 0;
            fired_now = 1;
        end
        bus.imem_ack_i   = ack;
        bus.imem_rdata_i = ack ? mem_word(bus.imem_addr_o) : 32'hBAD0_BAD0;
        #1;
        pw = bus.pc_write_o;
        np = bus.new_pc_o;
        if (reset) begin
            vectors++;
            if (bus.instr_valid_o !== (sb_pc.size() != 0)) begin
                miscompares++;
                $display("FAIL instr_valid: got %b want %b", bus.instr_valid_o, sb_pc.size() != 0);
            end
            acc = ack && !squashed && !bus.redirect_i;
            exp_pw = !(bus.redirect_i || acc);
            exp_np = bus.redirect_i ? bus.redirect_pc_i : (acc ? held_addr + 32'd4 : bus.pc_value_i);
            vectors++;
            if (pw !== exp_pw) begin
                miscompares++;
                $display("FAIL pc_write: got %b want %b", pw, exp_pw);
            end
            vectors++;
            if (np !== exp_np) begin
                miscompares++;
                $display("FAIL new_pc: got %h want %h", np, exp_np);
            end
            if (bus.redirect_i) begin
                sb_pc.delete();
                sb_instr.delete();
            end else begin
                if (bus.instr_valid_o && bus.instr_ready_i) begin
                    vectors++;
                    if (sb_pc.size() == 0) begin
                        miscompares++;
                        $display("FAIL pop_empty: got pc %h want no valid word", bus.instr_pc_o);
                    end else begin
                        if (bus.instr_pc_o !== sb_pc[0] || bus.instr_o !== sb_instr[0]) begin
                            miscompares++;
                            $display("FAIL pop_word: got %h/%h want %h/%h",
                                     bus.instr_pc_o, bus.instr_o, sb_pc[0], sb_instr[0]);
                        end else begin
                            $display("pop pc=%h instr=%h", bus.instr_pc_o, bus.instr_o);
                        end
                        void'(sb_pc.pop_front());
                        void'(sb_instr.pop_front());
                    end
                end
                if (acc) begin
                    sb_pc.push_back(held_addr);
                    sb_instr.push_back(mem_word(held_addr));
                end
            end
            if (acc) begin
                acks_taken++;
                ack_np_log.push_back(np);
            end
            if (ack && !acc) acks_dropped++;
            if (fired_now) fired_np = np;
            if (ack) squashed = 0;
            else if (bus.imem_req_o && bus.redirect_i) squashed = 1;
        end else begin
            sb_pc.delete();
            sb_instr.delete();
            squashed = 0;
        end
        @(posedge clk);
        #1;
        if (reset && !pw) bus.pc_value_i = np;
        if (fired_now) begin
            bus.redirect_i    = 1'b0;
            bus.instr_ready_i = 1'b0;
            fired_cnt++;
        end
    endtask

    task automatic do_reset(input logic [31:0] pc_init);
        reset = 1'b0;
        bus.pc_value_i    = pc_init;
        bus.redirect_i    = 1'b0;
        bus.instr_ready_i = 1'b0;
        rand_lat = 0;
        repeat (2) cyc();
        reset = 1'b1;
        issue_log.delete();
        ack_np_log.delete();
        acks_taken = 0;
        acks_dropped = 0;
        fired_cnt = 0;
        arm_redirect = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h0 || bus.instr_valid_o !== 1'b0 ||
            bus.instr_o !== 32'h0 || bus.instr_pc_o !== RESET_PC || bus.misaligned_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s regs: got req=%b addr=%h v=%b i=%h ipc=%h mis=%b want 0 0 0 0 %h 0",
                     tag, bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o, bus.instr_o,
                     bus.instr_pc_o, bus.misaligned_o, RESET_PC);
        end
        vectors++;
        if (bus.pc_write_o !== 1'b1 || bus.new_pc_o !== bus.pc_value_i) begin
            miscompares++;
            $display("FAIL %s pc_strobe: got %b/%h want 1/%h", tag, bus.pc_write_o, bus.new_pc_o,
                     bus.pc_value_i);
        end
    endtask

    task automatic test_reset();
        do_reset(RESET_PC);
        check_reset_outputs("reset");
    endtask

    task automatic test_single_fetch();
        do_reset(RESET_PC);
        mem_lat = 1;
        bus.instr_ready_i = 1'b1;
        for (int i = 0; i < 20 && ack_np_log.size() < 1; i++) cyc();
        vectors++;
        if (ack_np_log.size() < 1 || issue_log.size() < 1) begin
            miscompares++;
            $display("FAIL single_timeout: got %0d acks want 1", ack_np_log.size());
        end else if (issue_log[0] !== 32'h0040_0000 || ack_np_log[0] !== 32'h0040_0004) begin
            miscompares++;
            $display("FAIL single_fetch: got addr %h next %h want 00400000 00400004",
                     issue_log[0], ack_np_log[0]);
        end
        repeat (4) cyc();
    endtask

    task automatic test_fill();
        do_reset(RESET_PC);
        mem_lat = 0;
        bus.instr_ready_i = 1'b0;
        repeat (12) cyc();
        vectors++;
        if (acks_taken != 2 || bus.imem_req_o !== 1'b0 || bus.pc_write_o !== 1'b1 ||
            bus.pc_value_i !== 32'h0040_0008) begin
            miscompares++;
            $display("FAIL fill_stall: got acks=%0d req=%b pw=%b pc=%h want 2 0 1 00400008",
                     acks_taken, bus.imem_req_o, bus.pc_write_o, bus.pc_value_i);
        end
        bus.instr_ready_i = 1'b1;
        repeat (6) cyc();
        bus.instr_ready_i = 1'b0;
    endtask

    task automatic test_redirect_drop();
        do_reset(RESET_PC);
        mem_lat = 3;
        bus.instr_ready_i = 1'b1;
        for (int i = 0; i < 10 && !bus.imem_req_o; i++) cyc();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0040_0100;
        cyc();
        bus.redirect_i = 1'b0;
        for (int i = 0; i < 20 && issue_log.size() < 2; i++) cyc();
        vectors++;
        if (issue_log.size() < 2 || issue_log[1] !== 32'h0040_0100 || acks_dropped != 1 ||
            acks_taken != 0) begin
            miscompares++;
            $display("FAIL redirect_drop: got issues=%0d dropped=%0d taken=%0d want 2 1 0",
                     issue_log.size(), acks_dropped, acks_taken);
        end
        for (int i = 0; i < 10 && ack_np_log.size() < 1; i++) cyc();
        vectors++;
        if (ack_np_log.size() < 1 || ack_np_log[0] !== 32'h0040_0104) begin
            miscompares++;
            $display("FAIL redirect_resume: got %0d acks want next pc 00400104", ack_np_log.size());
        end
        repeat (3) cyc();
    endtask

    task automatic test_redirect_ack_pop();
        do_reset(RESET_PC);
        mem_lat = 2;
        bus.instr_ready_i = 1'b0;
        for (int i = 0; i < 30 && !(sb_pc.size() == 1 && bus.imem_req_o); i++) cyc();
        arm_target = 32'h0040_0300;
        arm_redirect = 1;
        for (int i = 0; i < 10 && fired_cnt == 0; i++) cyc();
        vectors++;
        if (fired_cnt != 1 || fired_np !== 32'h0040_0300 || bus.pc_value_i !== 32'h0040_0300) begin
            miscompares++;
            $display("FAIL redirect_ack_pc: got fired=%0d np=%h pc=%h want 1 00400300",
                     fired_cnt, fired_np, bus.pc_value_i);
        end
        vectors++;
        if (bus.instr_valid_o !== 1'b0 || acks_taken != 1) begin
            miscompares++;
            $display("FAIL redirect_ack_flush: got valid=%b acks=%0d want 0 1",
                     bus.instr_valid_o, acks_taken);
        end
        arm_redirect = 0;
        repeat (3) cyc();
    endtask

    task automatic test_misaligned();
        do_reset(32'h0040_0002);
        mem_lat = 0;
        repeat (5) cyc();
        vectors++;
        if (bus.misaligned_o !== 1'b1 || issue_log.size() != 0 || bus.imem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned_set: got mis=%b issues=%0d want 1 0",
                     bus.misaligned_o, issue_log.size());
        end
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0040_0200;
        cyc();
        bus.redirect_i = 1'b0;
        repeat (5) cyc();
        vectors++;
        if (bus.misaligned_o !== 1'b1 || issue_log.size() != 0 || bus.pc_value_i !== 32'h0040_0200) begin
            miscompares++;
            $display("FAIL misaligned_sticky: got mis=%b issues=%0d pc=%h want 1 0 00400200",
                     bus.misaligned_o, issue_log.size(), bus.pc_value_i);
        end
        do_reset(32'h0040_0200);
        repeat (4) cyc();
        vectors++;
        if (bus.misaligned_o !== 1'b0 || issue_log.size() == 0) begin
            miscompares++;
            $display("FAIL misaligned_clear: got mis=%b issues=%0d want 0 >0",
                     bus.misaligned_o, issue_log.size());
        end
    endtask

    task automatic test_reset_mid_wrap();
        do_reset(RESET_PC);
        mem_lat = 0;
        bus.instr_ready_i = 1'b0;
        for (int i = 0; i < 20 && !(sb_pc.size() == 1 && bus.imem_req_o); i++) cyc();
        reset = 1'b0;
        cyc();
        check_reset_outputs("mid_reset");
        bus.pc_value_i = 32'hFFFF_FFFC;
        reset = 1'b1;
        issue_log.delete();
        ack_np_log.delete();
        for (int i = 0; i < 10 && ack_np_log.size() < 1; i++) cyc();
        vectors++;
        if (ack_np_log.size() < 1 || issue_log[0] !== 32'hFFFF_FFFC || ack_np_log[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got %0d acks want addr fffffffc next 00000000", ack_np_log.size());
        end
        repeat (2) cyc();
    endtask

    task automatic test_back_to_back();
        do_reset(RESET_PC);
        mem_lat = 0;
        bus.instr_ready_i = 1'b1;
        repeat (21) cyc();
        vectors++;
        if (acks_taken != 10) begin
            miscompares++;
            $display("FAIL back_to_back: got %0d words want 10", acks_taken);
        end
    endtask

    task automatic test_random();
        do_reset(RESET_PC);
        rand_lat = 1;
        for (int i = 0; i < 300; i++) begin
            bus.instr_ready_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                bus.redirect_i    = 1'b1;
                bus.redirect_pc_i = {16'h0040, 6'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            cyc();
            bus.redirect_i = 1'b0;
        end
        rand_lat = 0;
        bus.instr_ready_i = 1'b1;
        repeat (8) cyc();
    endtask

    initial begin
        bus.pc_value_i    = RESET_PC;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_ack_i    = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.instr_ready_i = 1'b0;
        test_reset();
        test_single_fetch();
        test_fill();
        test_redirect_drop();
        test_redirect_ack_pop();
        test_misaligned();
        test_reset_mid_wrap();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
